// File: rtl/rotator_arbiter.sv
// rotator_arbiter: round-robin sharing of one external 8-bit rotator between two requesters.
// Optional ZERO_AMT_BYPASS_EN: zero-amount requests skip the rotator and complete in one cycle.
`default_nettype none

module rotator_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [AW-1:0] req0_amt,
    input  logic          req0_lr,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [AW-1:0] req1_amt,
    input  logic          req1_lr,
    output logic [DW-1:0] rot_a,
    output logic [AW-1:0] rot_amt,
    output logic          rot_lr,
    input  logic [DW-1:0] rot_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_y,
    output logic          out_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q;
    logic          id_q;
    logic [DW-1:0] rot_a_q;
    logic [AW-1:0] rot_amt_q;
    logic          rot_lr_q;
    logic          out_valid_q;
    logic [DW-1:0] out_y_q;
    logic          out_id_q;

    logic          gnt;
    logic          acc;
    logic          accept;
    logic          byp;
    logic [DW-1:0] sel_a;
    logic [AW-1:0] sel_amt;
    logic          sel_lr;

    // Pointer only matters under contention; a lone requester always wins.
    always_comb begin
        gnt     = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        acc     = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        accept  = acc & (req0_valid | req1_valid);
        sel_a   = gnt ? req1_a   : req0_a;
        sel_amt = gnt ? req1_amt : req0_amt;
        sel_lr  = gnt ? req1_lr  : req0_lr;
    end

    assign req0_ready = acc & req0_valid & (gnt == 1'b0);
    assign req1_ready = acc & req1_valid & (gnt == 1'b1);

`ifdef ZERO_AMT_BYPASS_EN
    assign byp = (sel_amt == '0);
`else
    assign byp = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = byp ? DONE : CALC;
                end
            end
            CALC: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = accept ? (byp ? DONE : CALC) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            rot_a_q     <= '0;
            rot_amt_q   <= '0;
            rot_lr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_id_q    <= 1'b0;
        end else begin
            if (accept) begin
                rot_a_q   <= sel_a;
                rot_amt_q <= sel_amt;
                rot_lr_q  <= sel_lr;
                id_q      <= gnt;
                ptr_q     <= ~gnt;
            end
            // A bypassed accept in DONE replaces the retiring result directly.
            if (state_q == CALC) begin
                out_y_q     <= rot_y;
                out_id_q    <= id_q;
                out_valid_q <= 1'b1;
            end else if (accept && byp) begin
                out_y_q     <= sel_a;
                out_id_q    <= gnt;
                out_valid_q <= 1'b1;
            end else if ((state_q == DONE) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign rot_a     = rot_a_q;
    assign rot_amt   = rot_amt_q;
    assign rot_lr    = rot_lr_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_id    = out_id_q;

endmodule

`default_nettype wire
